// File: rtl/cld_clk_gate_ctrl.sv
`timescale 1ns/1ps
// Multi-channel clock-gate controller: per-channel req/ack wake, idle hysteresis, DFT overrides.
// Define CLD_CLK_GATE_STAT_EN to add per-channel saturating OFF-cycle counters (stat_clr_i / stat_cnt_o).

module cld_clk_gate_leaf (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic gclk_o
);
    logic en_lat;

    // NOTE: this latch is intended; it freezes the enable through the high phase so gclk_o cannot glitch.
    always_latch begin
        if (!clk_i) en_lat <= en_i | test_en_i;
    end

    assign gclk_o = clk_i & en_lat;
endmodule

module cld_clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dft_mode_test_mode_i,
    input  logic                 dft_mode_scan_mode_i,
    input  logic                 dft_mode_scan_shift_i,
    input  logic                 dft_mode_mbist_mode_i,
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [NUM_CH-1:0]    sw_en_i,
    input  logic [IDLE_W-1:0]    idle_thr_i,
`ifdef CLD_CLK_GATE_STAT_EN
    input  logic                 stat_clr_i,
    output logic [NUM_CH*16-1:0] stat_cnt_o,
`endif
    output logic [NUM_CH-1:0]    ack_o,
    output logic [NUM_CH-1:0]    gated_o,
    output logic [NUM_CH-1:0]    gclk_o
);
    localparam int WCNT_W = $clog2(WAKE_LAT + 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_ON,
        ST_IDLE
    } state_e;

    logic [1:0] rst_sync_q;
    logic       rst_int;
    logic       dft_force;
    logic       unused_scan_mode;

    // Reset asserts immediately but releases two clk_i edges later, aligned to the clock.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst_int          = rst_sync_q[1];
    assign dft_force        = dft_mode_test_mode_i | dft_mode_mbist_mode_i;
    assign unused_scan_mode = dft_mode_scan_mode_i;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_e            state_q, state_d;
        logic [WCNT_W-1:0] wcnt_q, wcnt_d;
        logic [IDLE_W-1:0] icnt_q, icnt_d;
        logic              act;
        logic              fen;

        assign act = req_i[ch] | sw_en_i[ch];

        always_ff @(posedge clk_i or posedge rst_int) begin
            if (rst_int) begin
                state_q <= ST_OFF;
                wcnt_q  <= '0;
                icnt_q  <= '0;
            end else begin
                state_q <= state_d;
                wcnt_q  <= wcnt_d;
                icnt_q  <= icnt_d;
            end
        end

        // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
        always_comb begin
            state_d = state_q;
            wcnt_d  = wcnt_q;
            icnt_d  = icnt_q;
            unique case (state_q)
                ST_OFF: begin
                    if (act) begin
                        state_d = ST_WAKE;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
                ST_WAKE: begin
                    // act is ignored here so a started wake always reaches ack.
                    if (wcnt_q == WCNT_W'(WAKE_LAT)) state_d = ST_ON;
                    else                             wcnt_d  = wcnt_q + 1'b1;
                end
                ST_ON: begin
                    if (!act) begin
                        if (idle_thr_i == '0) begin
                            state_d = ST_OFF;
                        end else begin
                            state_d = ST_IDLE;
                            icnt_d  = IDLE_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (act) begin
                        state_d = ST_ON;
                        icnt_d  = '0;
                    end else if (icnt_q >= idle_thr_i) begin
                        state_d = ST_OFF;
                    end else if (icnt_q != '1) begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        assign fen         = (state_q != ST_OFF);
        assign ack_o[ch]   = (state_q == ST_ON) || (state_q == ST_IDLE);
        assign gated_o[ch] = ~fen;

        cld_clk_gate_leaf u_leaf (
            .clk_i     (clk_i),
            .en_i      (fen | dft_force),
            .test_en_i (dft_mode_scan_shift_i),
            .gclk_o    (gclk_o[ch])
        );

`ifdef CLD_CLK_GATE_STAT_EN
        logic [15:0] stat_q;

        // Clear wins over the increment in the same cycle.
        always_ff @(posedge clk_i or posedge rst_int) begin
            if (rst_int)                                  stat_q <= '0;
            else if (stat_clr_i)                          stat_q <= '0;
            else if (state_q == ST_OFF && stat_q != '1)   stat_q <= stat_q + 16'd1;
        end

        assign stat_cnt_o[ch*16 +: 16] = stat_q;
`endif
    end
endmodule

// File: tb/tb_cld_clk_gate_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for cld_clk_gate_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against ack_o, gated_o, gclk_o activity and stat_cnt_o.

module tb_cld_clk_gate_ctrl;
    localparam int NUM_CH   = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_LAT = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              dft_mode_test_mode_i;
    logic              dft_mode_scan_mode_i;
    logic              dft_mode_scan_shift_i;
    logic              dft_mode_mbist_mode_i;
    logic [NUM_CH-1:0] req_i;
    logic [NUM_CH-1:0] sw_en_i;
    logic [IDLE_W-1:0] idle_thr_i;
    logic [NUM_CH-1:0] ack_o;
    logic [NUM_CH-1:0] gated_o;
    logic [NUM_CH-1:0] gclk_o;
`ifdef CLD_CLK_GATE_STAT_EN
    logic                 stat_clr_i;
    logic [NUM_CH*16-1:0] stat_cnt_o;
`endif

    typedef struct {
        int          cyc;
        string       nm;
        bit          chk_st;
        logic [3:0]  ack;
        logic [3:0]  gated;
        bit          chk_clk;
        logic [3:0]  clk_act;
        bit          chk_stat;
        logic [15:0] stat;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ecnt_w   [NUM_CH];
    int   ecnt_last[NUM_CH];

    cld_clk_gate_ctrl #(
        .NUM_CH   (NUM_CH),
        .IDLE_W   (IDLE_W),
        .WAKE_LAT (WAKE_LAT)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .dft_mode_test_mode_i  (dft_mode_test_mode_i),
        .dft_mode_scan_mode_i  (dft_mode_scan_mode_i),
        .dft_mode_scan_shift_i (dft_mode_scan_shift_i),
        .dft_mode_mbist_mode_i (dft_mode_mbist_mode_i),
        .req_i                 (req_i),
        .sw_en_i               (sw_en_i),
        .idle_thr_i            (idle_thr_i),
`ifdef CLD_CLK_GATE_STAT_EN
        .stat_clr_i            (stat_clr_i),
        .stat_cnt_o            (stat_cnt_o),
`endif
        .ack_o                 (ack_o),
        .gated_o               (gated_o),
        .gclk_o                (gclk_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
        int n = 0;
        always @(posedge gclk_o[g]) n = n + 1;
        assign ecnt_w[g] = n;
    end

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(exp_t e);
        int idx = 0;
        while (idx < sb_q.size() && sb_q[idx].cyc <= e.cyc) idx++;
        sb_q.insert(idx, e);
    endtask

    task automatic exp_st(int at, string nm, logic [3:0] a, logic [3:0] g);
        exp_t e;
        e = '{cyc: at, nm: nm, chk_st: 1'b1, ack: a, gated: g,
              chk_clk: 1'b0, clk_act: 4'h0, chk_stat: 1'b0, stat: 16'h0};
        push(e);
    endtask

    task automatic exp_clk(int at, string nm, logic [3:0] a, logic [3:0] g, logic [3:0] c);
        exp_t e;
        e = '{cyc: at, nm: nm, chk_st: 1'b1, ack: a, gated: g,
              chk_clk: 1'b1, clk_act: c, chk_stat: 1'b0, stat: 16'h0};
        push(e);
    endtask

`ifdef CLD_CLK_GATE_STAT_EN
    task automatic exp_stat(int at, string nm, logic [15:0] s);
        exp_t e;
        e = '{cyc: at, nm: nm, chk_st: 1'b0, ack: 4'h0, gated: 4'h0,
              chk_clk: 1'b0, clk_act: 4'h0, chk_stat: 1'b1, stat: s};
        push(e);
    endtask
`endif

    // Monitor: each negedge, gclk activity over the last cycle plus any due expectations.
    always @(negedge clk_i) begin
        exp_t       e;
        logic [3:0] act_v;
        for (int i = 0; i < NUM_CH; i++) begin
            act_v[i]     = (ecnt_w[i] != ecnt_last[i]);
            ecnt_last[i] = ecnt_w[i];
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) check({e.nm, "_missed"}, 64'(cyc), 64'(e.cyc));
            if (e.chk_st) begin
                check({e.nm, "_ack"},   64'(ack_o),   64'(e.ack));
                check({e.nm, "_gated"}, 64'(gated_o), 64'(e.gated));
            end
            if (e.chk_clk) check({e.nm, "_gclk"}, 64'(act_v), 64'(e.clk_act));
`ifdef CLD_CLK_GATE_STAT_EN
            if (e.chk_stat) check({e.nm, "_stat3"}, 64'(stat_cnt_o[63:48]), 64'(e.stat));
`endif
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        req_i                 = '0;
        sw_en_i               = '0;
        idle_thr_i            = '0;
        dft_mode_test_mode_i  = 1'b0;
        dft_mode_scan_mode_i  = 1'b0;
        dft_mode_scan_shift_i = 1'b0;
        dft_mode_mbist_mode_i = 1'b0;
`ifdef CLD_CLK_GATE_STAT_EN
        stat_clr_i            = 1'b0;
`endif
        #1 rst_i = 1'b1;
        tick(3);
        rst_i = 1'b0;
        tick(4);

        // Reset then idle: everything gated, no clock pulses.
        c = cyc;
        exp_clk(c + 1, "rst_idle_a", 4'h0, 4'hF, 4'h0);
        exp_clk(c + 2, "rst_idle_b", 4'h0, 4'hF, 4'h0);
        tick(3);

        // Wake latency on channel 0.
        c = cyc;
        req_i[0] = 1'b1;
        exp_clk(c + 1, "wake_e0", 4'h0, 4'hE, 4'h0);
        exp_clk(c + 2, "wake_e1", 4'h0, 4'hE, 4'h1);
        exp_clk(c + 3, "wake_e2", 4'h1, 4'hE, 4'h1);
        tick(4);

        // Idle hysteresis, threshold 3, on channel 1.
        idle_thr_i = 8'd3;
        req_i[1]   = 1'b1;
        tick(4);
        c = cyc;
        req_i[1] = 1'b0;
        exp_st (c + 1, "idle_k",    4'h3, 4'hC);
        exp_st (c + 3, "idle_k2",   4'h3, 4'hC);
        exp_clk(c + 4, "idle_k3",   4'h1, 4'hE, 4'h3);
        exp_clk(c + 5, "idle_post", 4'h1, 4'hE, 4'h1);
        tick(6);

        // Re-raise during IDLE: ack never drops.
        req_i[1] = 1'b1;
        tick(4);
        c = cyc;
        req_i[1] = 1'b0;
        for (int i = 1; i <= 5; i++) exp_st(c + i, "reraise", 4'h3, 4'hC);
        tick(2);
        req_i[1] = 1'b1;
        tick(4);

        // Zero threshold: gate closes on the first edge without act.
        idle_thr_i = 8'd0;
        c = cyc;
        req_i[1] = 1'b0;
        exp_st(c + 1, "thr0", 4'h1, 4'hE);
        tick(2);

        // One-cycle request on channel 2 still completes the wake.
        c = cyc;
        req_i[2] = 1'b1;
        exp_st(c + 1, "glitch_w0", 4'h1, 4'hA);
        exp_st(c + 2, "glitch_w1", 4'h1, 4'hA);
        exp_st(c + 3, "glitch_on", 4'h5, 4'hA);
        exp_st(c + 4, "glitch_off", 4'h1, 4'hE);
        exp_st(c + 5, "glitch_off2", 4'h1, 4'hE);
        tick(1);
        req_i[2] = 1'b0;
        tick(5);

        // Software force-on on channel 3.
        c = cyc;
        sw_en_i[3] = 1'b1;
        exp_st(c + 3, "sw_en_on", 4'h9, 4'h6);
        tick(4);
        c = cyc;
        sw_en_i[3] = 1'b0;
        exp_st(c + 1, "sw_en_off", 4'h1, 4'hE);
        tick(2);

        // Reset while channel 0 is ON: outputs clear before the next edge.
        c = cyc;
        rst_i = 1'b1;
        req_i = '0;
        exp_st(c, "rst_mid", 4'h0, 4'hF);
        tick(2);
        rst_i = 1'b0;
        tick(4);
        c = cyc;
        exp_clk(c + 1, "post_rst", 4'h0, 4'hF, 4'h0);
        tick(2);

        // DFT overrides: clocks run, FSM outputs untouched.
        c = cyc;
        dft_mode_mbist_mode_i = 1'b1;
        exp_clk(c + 1, "mbist_a", 4'h0, 4'hF, 4'hF);
        exp_clk(c + 2, "mbist_b", 4'h0, 4'hF, 4'hF);
        tick(2);
        c = cyc;
        dft_mode_mbist_mode_i = 1'b0;
        exp_clk(c + 1, "mbist_off", 4'h0, 4'hF, 4'h0);
        tick(2);
        c = cyc;
        dft_mode_test_mode_i = 1'b1;
        exp_clk(c + 1, "test_mode", 4'h0, 4'hF, 4'hF);
        tick(2);
        c = cyc;
        dft_mode_test_mode_i = 1'b0;
        dft_mode_scan_mode_i = 1'b1;
        exp_clk(c + 1, "scan_mode_only_a", 4'h0, 4'hF, 4'h0);
        exp_clk(c + 2, "scan_mode_only_b", 4'h0, 4'hF, 4'h0);
        tick(2);
        c = cyc;
        dft_mode_scan_shift_i = 1'b1;
        exp_clk(c + 1, "scan_shift", 4'h0, 4'hF, 4'hF);
        tick(2);
        c = cyc;
        dft_mode_scan_shift_i = 1'b0;
        dft_mode_scan_mode_i  = 1'b0;
        exp_clk(c + 1, "dft_off", 4'h0, 4'hF, 4'h0);
        tick(2);

`ifdef CLD_CLK_GATE_STAT_EN
        // OFF-cycle statistics on channel 3.
        c = cyc;
        stat_clr_i = 1'b1;
        exp_stat(c + 1, "stat_clr0", 16'd0);
        tick(1);
        stat_clr_i = 1'b0;
        exp_stat(c + 21, "stat_20", 16'd20);
        tick(21);
        c = cyc;
        stat_clr_i = 1'b1;
        exp_stat(c + 1, "stat_clr1", 16'd0);
        tick(1);
        stat_clr_i = 1'b0;
        c = cyc;
        exp_stat(c + 70000, "stat_sat", 16'hFFFF);
        tick(70001);
`endif

        repeat (10) if (sb_q.size() > 0) tick(1);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cld_clk_gate_ctrl.md
Name: cld_clk_gate_ctrl

Overview:
- Multi-channel clock-gate controller and successor to the single-enable gate wrapper.
- Generates NUM_CH gated clocks from one clk_i, each through one cld_clk_gate_leaf instance.
- Each channel has a req/ack wake handshake, a programmable idle hysteresis before auto-gating, and DFT overrides.
- Sits at subsystem clock roots between the power-management logic and the gated clock domains.

Parameters:
- NUM_CH, 4: number of gated clock channels (>=1).
- IDLE_W, 8: width of the idle-threshold counter.
- WAKE_LAT, 2: cycles from gate enable to ack_o (>=1). Covers clock-tree settling.

Ports:
- clk_i  in  1  source clock.
- rst_i  in  1  reset, asynchronous, active-high.
- dft_mode_test_mode_i  in  1  forces all gates open.
- dft_mode_scan_mode_i  in  1  scan mode. No effect on the FSM; reserved, tied into the leaf test path only via scan_shift.
- dft_mode_scan_shift_i  in  1  drives leaf test_en_i on every channel.
- dft_mode_mbist_mode_i  in  1  forces all gates open.
- req_i  in  NUM_CH  per-channel clock request (level).
- sw_en_i  in  NUM_CH  per-channel software force-on (level). Treated as a request.
- idle_thr_i  in  IDLE_W  shared idle cycles before gating; sampled every cycle.
- ack_o  out  NUM_CH  clock running and stable.
- gated_o  out  NUM_CH  1 = channel gate closed by the FSM.
- gclk_o  out  NUM_CH  gated clocks.

Behaviour:
- Reset: every channel goes to OFF. ack_o=0, gated_o=all 1s, FSM enables 0, counters 0. Asynchronous assert, synchronous release.
- Per channel, act = req_i[n] | sw_en_i[n].
- FSM states and registered enable (fen) / ack per state:
  - OFF: fen=0, ack=0.
  - WAKE: fen=1, ack=0.
  - ON: fen=1, ack=1.
  - IDLE: fen=1, ack=1.
- OFF: act=1 -> WAKE, wcnt=1.
- WAKE: if wcnt==WAKE_LAT -> ON, else wcnt++. act is ignored in WAKE: no abort, so the ack always completes.
- ON: act=0 and idle_thr_i==0 -> OFF. act=0 and idle_thr_i!=0 -> IDLE, icnt=1. Otherwise stay.
- IDLE: act=1 -> ON (icnt cleared). Else icnt>=idle_thr_i -> OFF. Else icnt++.
  - The >= compare handles idle_thr_i shrinking mid-count.
  - icnt saturates at all-ones.
- Timing: act high before edge 0 gives fen=1 after edge 0 and ack_o=1 after edge WAKE_LAT.
  - Clock pulses reach gclk_o from the cycle following the fen rise (leaf latch).
- Idle timing: act falls before edge k, threshold T>0. fen falls after edge k+T, so T extra enabled cycles.
- Leaf connections per channel:
  - en_i = fen | dft_mode_test_mode_i | dft_mode_mbist_mode_i.
  - test_en_i = dft_mode_scan_shift_i.
- DFT overrides change only the leaf enable. FSM, ack_o and gated_o are unaffected.
- gated_o = ~fen. It is registered, with no combinational path from inputs to ack_o or gated_o.
- Channels are fully independent. Simultaneous act edges on several channels are each handled in parallel.
- Reset mid-operation: any state -> OFF immediately. The leaf latch closes on the next low phase of clk_i.

Optional Feature:
- Macro CLD_CLK_GATE_STAT_EN.
- Defined:
  - Adds input stat_clr_i (1) and output stat_cnt_o (NUM_CH*16).
  - Per-channel saturating 16-bit count of cycles spent in OFF.
  - stat_clr_i=1 zeroes all counters on the next edge. It takes priority over the increment in the same cycle.
  - Counters are reset to 0 by rst_i.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Reset then idle: rst_i pulse, all inputs 0 -> ack_o=0, gated_o=4'hF, no gclk_o edges. Assert rst_i mid-ON -> ack_o=0 immediately.
- Wake latency: WAKE_LAT=2, req_i[0] rises before edge 0 -> gated_o[0]=0 after edge 0, ack_o[0]=1 after edge 2, gclk_o[0] toggles; other channels stay gated.
- Idle hysteresis: idle_thr_i=3, drop req_i[1] before edge k -> gated_o[1]=1 after edge k+3. Re-raise req_i[1] at k+2 -> stays ON and ack_o never drops. idle_thr_i=0 -> gated after edge k.
- Req glitch in WAKE: req_i[2] high for 1 cycle -> passes WAKE, ack_o[2] high exactly 1 cycle (ON), then OFF with idle_thr_i=0.
- DFT: all channels OFF, mbist_mode_i=1 -> all gclk_o toggle while ack_o=0 and gated_o=4'hF. scan_shift_i=1 -> clocks toggle through the leaf test enable.
- CLD_CLK_GATE_STAT_EN: channel 3 OFF for 20 cycles -> stat_cnt_o[63:48]=20. stat_clr_i pulse -> 0. Forced 70000 OFF cycles -> saturates at 16'hFFFF.
